// File: rtl/case_1_traffic_ctrl.sv
// Fixed-time Moore controller for a T junction: six phases cycle S1..S6, each held
// for a parameterised number of clk ticks. Lamps are one-hot {R,Y,G} and depend on state only.
module case_1_traffic_ctrl #(
  parameter int T_MAIN = 7,
  parameter int T_YEL  = 2,
  parameter int T_TURN = 5,
  parameter int T_SIDE = 3,
  parameter int CNT_W  = 5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S1 = 3'd0;
  localparam logic [2:0] S2 = 3'd1;
  localparam logic [2:0] S3 = 3'd2;
  localparam logic [2:0] S4 = 3'd3;
  localparam logic [2:0] S5 = 3'd4;
  localparam logic [2:0] S6 = 3'd5;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_last;

  // Terminal count and successor for the current phase.
  always_comb begin
    count_last = CNT_W'(T_MAIN - 1);
    state_nxt  = S1;
    case (state)
      S1: begin count_last = CNT_W'(T_MAIN - 1); state_nxt = S2; end
      S2: begin count_last = CNT_W'(T_YEL - 1);  state_nxt = S3; end
      S3: begin count_last = CNT_W'(T_TURN - 1); state_nxt = S4; end
      S4: begin count_last = CNT_W'(T_YEL - 1);  state_nxt = S5; end
      S5: begin count_last = CNT_W'(T_SIDE - 1); state_nxt = S6; end
      S6: begin count_last = CNT_W'(T_YEL - 1);  state_nxt = S1; end
      default: begin count_last = CNT_W'(T_MAIN - 1); state_nxt = S1; end
    endcase
  end

  // Reset outranks a due transition; unused encodings fall back to a fresh S1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S1;
      count <= '0;
    end else if (state > S6) begin
      state <= S1;
      count <= '0;
    end else if (count == count_last) begin
      state <= state_nxt;
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Lamp decode; an illegal state shows all-red for its single cycle.
  always_comb begin
    light_M1 = RED;
    light_M2 = RED;
    light_MT = RED;
    light_S  = RED;
    case (state)
      S1: begin light_M1 = GRN; light_M2 = GRN; end
      S2: begin light_M1 = GRN; light_M2 = YEL; end
      S3: begin light_M1 = GRN; light_MT = GRN; end
      S4: begin light_M1 = YEL; light_MT = YEL; end
      S5: light_S = GRN;
      S6: light_S = YEL;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_case_1_traffic_ctrl.sv
// Bench for case_1_traffic_ctrl: default instance plus a shortened-timing instance,
// both compared every cycle against a time-since-reset phase model.
module tb_case_1_traffic_ctrl;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [2:0] a_m1, a_m2, a_mt, a_s, a_st;
  logic [2:0] b_m1, b_m2, b_mt, b_s, b_st;

  int checks   = 0;
  int failures = 0;
  int t        = 0;

  // {state_a, lamps_a, lamps_b}
  logic [26:0] exp_q[$];

  always #5 clk = ~clk;

  case_1_traffic_ctrl dut_a (
    .clk(clk), .rst(rst),
    .light_M1(a_m1), .light_M2(a_m2), .light_MT(a_mt), .light_S(a_s),
    .state_dbg(a_st)
  );

  case_1_traffic_ctrl #(.T_MAIN(3), .T_YEL(1)) dut_b (
    .clk(clk), .rst(rst),
    .light_M1(b_m1), .light_M2(b_m2), .light_MT(b_mt), .light_S(b_s),
    .state_dbg(b_st)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Phase index for t cycles after reset release, from cumulative phase lengths.
  function automatic int phase_of(input int tt_in, input int tm, input int ty,
                                  input int tt, input int ts);
    int len[6];
    int p;
    len[0] = tm; len[1] = ty; len[2] = tt; len[3] = ty; len[4] = ts; len[5] = ty;
    p = tt_in % (tm + ty + tt + ty + ts + ty);
    for (int i = 0; i < 6; i++) begin
      if (p < len[i]) return i;
      p -= len[i];
    end
    return 0;
  endfunction

  function automatic logic [11:0] lamps_of(input int ph);
    case (ph)
      0:       return {GRN, GRN, RED, RED};
      1:       return {GRN, YEL, RED, RED};
      2:       return {GRN, RED, GRN, RED};
      3:       return {YEL, RED, YEL, RED};
      4:       return {RED, RED, RED, GRN};
      default: return {RED, RED, RED, YEL};
    endcase
  endfunction

  function automatic logic safe(input logic [2:0] m1, input logic [2:0] m2,
                                input logic [2:0] mt, input logic [2:0] s);
    logic ok;
    ok = $onehot(m1) && $onehot(m2) && $onehot(mt) && $onehot(s);
    if (s != RED && !(m1 == RED && m2 == RED && mt == RED)) ok = 1'b0;
    if (mt != RED && m2 != RED) ok = 1'b0;
    if (m2 == GRN && mt != RED) ok = 1'b0;
    return ok;
  endfunction

  // One clock: drive rst, advance the model at the edge, compare at the falling edge.
  task automatic step(input logic r);
    logic [26:0] e;
    int pa;
    rst = r;
    @(posedge clk);
    if (!r) t = 0;
    else t++;
    pa = phase_of(t, 7, 2, 5, 3);
    exp_q.push_back({3'(pa), lamps_of(pa), lamps_of(phase_of(t, 3, 1, 5, 3))});
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("state_a", 32'(a_st), 32'(e[26:24]));
      check("lamps_a", 32'({a_m1, a_m2, a_mt, a_s}), 32'(e[23:12]));
      check("lamps_b", 32'({b_m1, b_m2, b_mt, b_s}), 32'(e[11:0]));
      check("safety_a", 32'(safe(a_m1, a_m2, a_mt, a_s)), 32'd1);
      check("safety_b", 32'(safe(b_m1, b_m2, b_mt, b_s)), 32'd1);
    end
  endtask

  initial begin
    // Reset held for two edges, then five full 21-cycle periods.
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 105; i++) step(1'b1);
    // Land in S5 (t=17), pulse reset for one edge, confirm a full-length S1 follows.
    for (int i = 0; i < 17; i++) step(1'b1);
    check("in_s5_before_reset", 32'(a_st), 32'd4);
    step(1'b0);
    for (int i = 0; i < 30; i++) step(1'b1);
    // Long monitored run.
    for (int i = 0; i < 200; i++) step(1'b1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
